ram_responder: RTL and testbench

Memory-side responder for the RAM port driven by the memory controller. Accepts word read/write requests on `ramREN`/`ramWEN`/`ramaddr`/`ramstore` and reports progress on `ramstate` (FREE/BUSY/ACCESS/ERROR from `cpu_types_pkg`). It inserts a programmable number of wait cycles before completing each access and returns read data on `ramload`. It serves as the RAM endpoint for cache and controller simulation and for FPGA bring-up.

---
 rtl/ram_responder_if.sv | 30 +++
 rtl/ram_responder.sv | 114 +++++++++++
 tb/tb_ram_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// RAM port types and the requester/responder bus bundle.
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

interface ram_responder_if;
    import cpu_types_pkg::*;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// Word RAM endpoint with LAT BUSY cycles before each ACCESS; status and
// read data are combinational from the current request and FSM state.
module ram_responder #(
    parameter int LAT   = 2,
    parameter int WORDS = 256
) (
    input  logic           CLK,
    input  logic           nRST,
    ram_responder_if.slave ram
);
    import cpu_types_pkg::*;

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = (LAT > 0) ? CW'(LAT - 1) : '0;

    typedef enum logic {IDLE, WAIT} fsm_t;

    typedef struct packed {
        logic          op;    // 1 = write
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } req_t;

    fsm_t          state;
    req_t          lat_q;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [WORDS];

    req_t          cur;
    logic          req, illegal, same;
    ramstate_t     rstate;
    logic [31:0]   rload;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;

    assign req = ram.ramREN | ram.ramWEN;
    assign illegal = req & ((ram.ramREN & ram.ramWEN)
                          | (ram.ramaddr[1:0] != 2'b00)
                          | ({2'b00, ram.ramaddr[31:2]} >= 32'(WORDS)));
    assign cur = '{op: ram.ramWEN, addr: ram.ramaddr[AW+1:2], data: ram.ramstore};
    // Read requests ignore ramstore, so only writes compare data.
    assign same = (cur.op == lat_q.op) && (cur.addr == lat_q.addr)
               && (!cur.op || (cur.data == lat_q.data));

    always_comb begin
        rstate  = FREE;
        rload   = '0;
        wr_en   = 1'b0;
        wr_addr = cur.addr;
        wr_data = cur.data;
        if (illegal) begin
            rstate = ERROR;
        end else if (state == IDLE) begin
            if (req) begin
                if (LAT == 0) begin
                    rstate = ACCESS;
                    if (cur.op) wr_en = 1'b1;
                    else        rload = mem[cur.addr];
                end else begin
                    rstate = BUSY;
                end
            end
        end else if (req) begin
            if (!same || cnt != '0) begin
                rstate = BUSY;
            end else begin
                rstate  = ACCESS;
                wr_addr = lat_q.addr;
                wr_data = lat_q.data;
                if (lat_q.op) wr_en = 1'b1;
                else          rload = mem[lat_q.addr];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            lat_q <= '0;
            cnt   <= '0;
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            if (wr_en) mem[wr_addr] <= wr_data;
            case (state)
                IDLE: begin
                    if (req && !illegal && LAT > 0) begin
                        lat_q <= cur;
                        cnt   <= CNT_RELOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (illegal || !req) begin
                        state <= IDLE;
                    end else if (!same) begin
                        // Changed request: restart full latency on the new one.
                        lat_q <= cur;
                        cnt   <= CNT_RELOAD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram.ramstate = rstate;
    assign ram.ramload  = rload;
endmodule

// File: tb/tb_ram_responder.sv
// Scenario bench for ram_responder: LAT=2 and LAT=0 builds side by side.
module tb_ram_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ram_responder_if r2 ();
    ram_responder_if r0 ();

    ram_responder #(.LAT(2), .WORDS(256)) dut2 (.CLK(CLK), .nRST(nRST), .ram(r2));
    ram_responder #(.LAT(0), .WORDS(256)) dut0 (.CLK(CLK), .nRST(nRST), .ram(r0));

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
        ramstate_t   st;
        logic [31:0] ld;
    } stim_t;

    typedef struct {
        ramstate_t   st;
        logic [31:0] ld;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];
    int    checks = 0;
    int    passes = 0;

    task automatic put(input logic ren, input logic wen, input logic [31:0] a,
                       input logic [31:0] d, input ramstate_t st, input logic [31:0] ld);
        stim_t s;
        s = '{ren: ren, wen: wen, addr: a, store: d, st: st, ld: ld};
        sq.push_back(s);
    endtask

    task automatic rd(input logic [31:0] a, input ramstate_t st, input logic [31:0] ld);
        put(1'b1, 1'b0, a, 32'h0, st, ld);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input ramstate_t st);
        put(1'b0, 1'b1, a, d, st, 32'h0);
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endtask

    task automatic drive(input bit sel, input stim_t s);
        if (sel) begin
            r0.ramREN = s.ren; r0.ramWEN = s.wen; r0.ramaddr = s.addr; r0.ramstore = s.store;
        end else begin
            r2.ramREN = s.ren; r2.ramWEN = s.wen; r2.ramaddr = s.addr; r2.ramstore = s.store;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        eq.push_back('{st: FREE, ld: 32'h0});
        eq.push_back('{st: FREE, ld: 32'h0});
        #12;
        e = eq.pop_front(); checks++;
        if (r2.ramstate !== e.st || r2.ramload !== e.ld)
            $display("FAIL reset_lat2: state %0d load %h, want %0d %h", r2.ramstate, r2.ramload, e.st, e.ld);
        else passes++;
        e = eq.pop_front(); checks++;
        if (r0.ramstate !== e.st || r0.ramload !== e.ld)
            $display("FAIL reset_lat0: state %0d load %h, want %0d %h", r0.ramstate, r0.ramload, e.st, e.ld);
        else passes++;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_read();
        stim_t s; exp_t e; int n;
        wr(32'h40, 32'hDEADBEEF, BUSY); wr(32'h40, 32'hDEADBEEF, BUSY);
        wr(32'h40, 32'hDEADBEEF, ACCESS); idle();
        rd(32'h40, BUSY, 0); rd(32'h40, BUSY, 0); rd(32'h40, ACCESS, 32'hDEADBEEF); idle();
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b0, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r2.ramstate !== e.st || r2.ramload !== e.ld)
                $display("FAIL read[%0d]: state %0d load %h, want %0d %h", n, r2.ramstate, r2.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
    endtask

    task automatic test_write_read();
        stim_t s; exp_t e; int n;
        wr(32'h8, 32'h12345678, BUSY); wr(32'h8, 32'h12345678, BUSY); wr(32'h8, 32'h12345678, ACCESS);
        rd(32'h8, BUSY, 0); rd(32'h8, BUSY, 0); rd(32'h8, ACCESS, 32'h12345678);
        rd(32'hC, BUSY, 0); rd(32'hC, BUSY, 0); rd(32'hC, ACCESS, 0); idle();
        // held read: every access re-pays the full latency
        for (int i = 0; i < 2; i++) begin
            rd(32'h8, BUSY, 0); rd(32'h8, BUSY, 0); rd(32'h8, ACCESS, 32'h12345678);
        end
        idle();
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b0, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r2.ramstate !== e.st || r2.ramload !== e.ld)
                $display("FAIL write_read[%0d]: state %0d load %h, want %0d %h", n, r2.ramstate, r2.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
    endtask

    task automatic test_abort();
        stim_t s; exp_t e; int n;
        wr(32'h10, 32'hAAAA5555, BUSY);
        wr(32'h14, 32'hAAAA5555, BUSY); wr(32'h14, 32'hAAAA5555, BUSY);
        wr(32'h14, 32'hAAAA5555, ACCESS); idle();
        rd(32'h10, BUSY, 0); rd(32'h10, BUSY, 0); rd(32'h10, ACCESS, 0);
        rd(32'h14, BUSY, 0); rd(32'h14, BUSY, 0); rd(32'h14, ACCESS, 32'hAAAA5555); idle();
        wr(32'h18, 32'h55555555, BUSY); wr(32'h18, 32'h55555555, BUSY); idle();
        rd(32'h18, BUSY, 0); rd(32'h18, BUSY, 0); rd(32'h18, ACCESS, 0); idle();
        wr(32'h24, 32'h00000001, BUSY);
        wr(32'h24, 32'h00000002, BUSY); wr(32'h24, 32'h00000002, BUSY);
        wr(32'h24, 32'h00000002, ACCESS);
        rd(32'h24, BUSY, 0); rd(32'h24, BUSY, 0); rd(32'h24, ACCESS, 32'h2); idle();
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b0, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r2.ramstate !== e.st || r2.ramload !== e.ld)
                $display("FAIL abort[%0d]: state %0d load %h, want %0d %h", n, r2.ramstate, r2.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
    endtask

    task automatic test_errors();
        stim_t s; exp_t e; int n;
        put(1'b1, 1'b1, 32'h40, 32'h0, ERROR, 0);
        rd(32'h2, ERROR, 0);
        wr(32'h42, 32'h5, ERROR);
        rd(32'h400, ERROR, 0);
        wr(32'h400, 32'h77, ERROR);
        idle();
        rd(32'h40, BUSY, 0); rd(32'h402, ERROR, 0);
        rd(32'h40, BUSY, 0); rd(32'h40, BUSY, 0); rd(32'h40, ACCESS, 32'hDEADBEEF); idle();
        rd(32'h0, BUSY, 0); rd(32'h0, BUSY, 0); rd(32'h0, ACCESS, 0); idle();
        wr(32'h3FC, 32'hCAFEF00D, BUSY); wr(32'h3FC, 32'hCAFEF00D, BUSY);
        wr(32'h3FC, 32'hCAFEF00D, ACCESS); idle();
        rd(32'h3FC, BUSY, 0); rd(32'h3FC, BUSY, 0); rd(32'h3FC, ACCESS, 32'hCAFEF00D); idle();
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b0, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r2.ramstate !== e.st || r2.ramload !== e.ld)
                $display("FAIL errors[%0d]: state %0d load %h, want %0d %h", n, r2.ramstate, r2.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t s; exp_t e; int n;
        wr(32'h20, 32'hFFFFFFFF, BUSY); wr(32'h20, 32'hFFFFFFFF, BUSY);
        wr(32'h20, 32'hFFFFFFFF, ACCESS);
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b0, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r2.ramstate !== e.st || r2.ramload !== e.ld)
                $display("FAIL rst_pre[%0d]: state %0d load %h, want %0d %h", n, r2.ramstate, r2.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
        // Reset lands mid-cycle; the held request now sees an idle FSM.
        #1 nRST = 1'b0;
        eq.push_back('{st: BUSY, ld: 32'h0});
        #1; e = eq.pop_front(); checks++;
        if (r2.ramstate !== e.st || r2.ramload !== e.ld)
            $display("FAIL rst_async: state %0d load %h, want %0d %h", r2.ramstate, r2.ramload, e.st, e.ld);
        else passes++;
        r2.ramWEN = 1'b0;
        eq.push_back('{st: FREE, ld: 32'h0});
        #1; e = eq.pop_front(); checks++;
        if (r2.ramstate !== e.st || r2.ramload !== e.ld)
            $display("FAIL rst_free: state %0d load %h, want %0d %h", r2.ramstate, r2.ramload, e.st, e.ld);
        else passes++;
        @(negedge CLK);
        nRST = 1'b1;
        rd(32'h20, BUSY, 0); rd(32'h20, BUSY, 0); rd(32'h20, ACCESS, 0);
        rd(32'h40, BUSY, 0); rd(32'h40, BUSY, 0); rd(32'h40, ACCESS, 0); idle();
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b0, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r2.ramstate !== e.st || r2.ramload !== e.ld)
                $display("FAIL rst_post[%0d]: state %0d load %h, want %0d %h", n, r2.ramstate, r2.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
    endtask

    task automatic test_lat0();
        stim_t s; exp_t e; int n;
        wr(32'h4, 32'h11111111, ACCESS);
        rd(32'h4, ACCESS, 32'h11111111); rd(32'h4, ACCESS, 32'h11111111); rd(32'h4, ACCESS, 32'h11111111);
        for (int i = 0; i < 4; i++) wr(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), ACCESS);
        for (int i = 0; i < 4; i++) rd(32'h10 + 32'(4 * i), ACCESS, 32'hA0 + 32'(i));
        rd(32'h1, ERROR, 0); idle();
        rd(32'h8, ACCESS, 0); idle();
        n = 0;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            @(posedge CLK); #1; drive(1'b1, s); eq.push_back('{st: s.st, ld: s.ld});
            @(negedge CLK); e = eq.pop_front(); checks++;
            if (r0.ramstate !== e.st || r0.ramload !== e.ld)
                $display("FAIL lat0[%0d]: state %0d load %h, want %0d %h", n, r0.ramstate, r0.ramload, e.st, e.ld);
            else passes++;
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        r2.ramREN = 1'b0; r2.ramWEN = 1'b0; r2.ramaddr = '0; r2.ramstore = '0;
        r0.ramREN = 1'b0; r0.ramWEN = 1'b0; r0.ramaddr = '0; r0.ramstore = '0;
        test_reset();
        test_read();
        test_write_read();
        test_abort();
        test_errors();
        test_reset_mid_write();
        test_lat0();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
